// File: rtl/csr_file_pkg.sv
// Shared definitions for the machine-mode CSR file: addresses, cause codes,
// mstatus field positions and redirect FSM encoding.
package csr_file_pkg;

   localparam logic [11:0] CSR_MSTATUS   = 12'h300;
   localparam logic [11:0] CSR_MTVEC     = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
   localparam logic [11:0] CSR_MEPC      = 12'h341;
   localparam logic [11:0] CSR_MCAUSE    = 12'h342;
   localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
   localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
   localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
   localparam logic [11:0] CSR_MVENDORID = 12'hF11;
   localparam logic [11:0] CSR_MARCHID   = 12'hF12;

   localparam logic [31:0] INST_ADDR_MISALIGNED  = 32'd0;
   localparam logic [31:0] INST_ACCESS_FAULT     = 32'd1;
   localparam logic [31:0] ILLEGAL_INST          = 32'd2;
   localparam logic [31:0] BREAKPOINT            = 32'd3;
   localparam logic [31:0] LOAD_ADDR_MISALIGNED  = 32'd4;
   localparam logic [31:0] LOAD_ACCESS_FAULT     = 32'd5;
   localparam logic [31:0] STORE_ADDR_MISALIGNED = 32'd6;
   localparam logic [31:0] STORE_ACCESS_FAULT    = 32'd7;
   localparam logic [31:0] ECALL_FROM_U_MODE     = 32'd8;
   localparam logic [31:0] ECALL_FROM_S_MODE     = 32'd9;
   localparam logic [31:0] ECALL_FROM_M_MODE     = 32'd11;

   localparam int MSTATUS_MIE    = 3;
   localparam int MSTATUS_MPIE   = 7;
   localparam int MSTATUS_MPP_LO = 11;

   typedef enum logic {
      IDLE     = 1'b0,
      REDIRECT = 1'b1
   } redir_state_t;

   // Only MIE/MPIE are stored; MPP is hardwired to machine mode.
   typedef struct packed {
      logic mpie;
      logic mie;
   } mstatus_t;

   function automatic logic [31:0] mstatus_pack(input mstatus_t s);
      logic [31:0] v;
      v = '0;
      v[MSTATUS_MPP_LO +: 2] = 2'b11;
      v[MSTATUS_MPIE]        = s.mpie;
      v[MSTATUS_MIE]         = s.mie;
      return v;
   endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with per-half load; a load on either half
// suppresses the increment for that cycle and no carry enters the loaded half.
module csr_counter64 (
   input  logic        clock,
   input  logic        arst_n,
   input  logic        inc,
   input  logic        we_lo,
   input  logic        we_hi,
   input  logic [31:0] wdata,
   output logic [63:0] count
);

   always_ff @(posedge clock or negedge arst_n) begin
      if (!arst_n) begin
         count <= '0;
      end else if (we_lo || we_hi) begin
         if (we_lo) count[31:0]  <= wdata;
         if (we_hi) count[63:32] <= wdata;
      end else if (inc) begin
         count <= count + 64'd1;
      end
   end

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file and trap sequencer; combinational read port, state updates next edge.
// Redirect is held valid with a stable PC until fetch accepts; a newer trap re-targets it.
module csr_file
   import csr_file_pkg::*;
#(
   parameter logic [31:0] MVENDORID   = 32'h79737978,
   parameter logic [31:0] MARCHID     = 32'h0,
   parameter logic [31:0] MSTATUS_RST = 32'h00001800
) (
   input  logic        clock,
   input  logic        arst_n,
   input  logic [11:0] rd_addr_i,
   output logic [31:0] rd_data_o,
   output logic        rd_illegal_o,
   input  logic        wb_csr_we_i,
   input  logic [11:0] wb_csr_addr_i,
   input  logic [31:0] wb_csr_wdata_i,
   input  logic        excp_flush_i,
   input  logic [31:0] excp_mcause_i,
   input  logic [31:0] excp_mepc_i,
   input  logic        mret_flush_i,
   input  logic        retire_i,
   output logic        redirect_valid_o,
   output logic [31:0] redirect_pc_o,
   input  logic        redirect_ready_i
);

   mstatus_t     mstatus;
   logic [31:0]  mtvec, mscratch, mepc, mcause;
   logic [63:0]  mcycle, minstret;
   redir_state_t state;

   logic        trap, csr_wr;
   logic [31:0] trap_target;

   assign trap        = excp_flush_i | mret_flush_i;
   assign csr_wr      = wb_csr_we_i & ~trap;
   assign trap_target = excp_flush_i ? mtvec : mepc;

   csr_counter64 u_mcycle (
      .clock (clock),
      .arst_n(arst_n),
      .inc   (1'b1),
      .we_lo (csr_wr && wb_csr_addr_i == CSR_MCYCLE),
      .we_hi (csr_wr && wb_csr_addr_i == CSR_MCYCLEH),
      .wdata (wb_csr_wdata_i),
      .count (mcycle)
   );

   csr_counter64 u_minstret (
      .clock (clock),
      .arst_n(arst_n),
      .inc   (retire_i),
      .we_lo (csr_wr && wb_csr_addr_i == CSR_MINSTRET),
      .we_hi (csr_wr && wb_csr_addr_i == CSR_MINSTRETH),
      .wdata (wb_csr_wdata_i),
      .count (minstret)
   );

   always_ff @(posedge clock or negedge arst_n) begin
      if (!arst_n) begin
         mstatus.mie  <= MSTATUS_RST[MSTATUS_MIE];
         mstatus.mpie <= MSTATUS_RST[MSTATUS_MPIE];
         mtvec        <= '0;
         mscratch     <= '0;
         mepc         <= '0;
         mcause       <= '0;
      end else if (excp_flush_i) begin
         mepc         <= excp_mepc_i & ~32'h3;
         mcause       <= excp_mcause_i;
         mstatus.mpie <= mstatus.mie;
         mstatus.mie  <= 1'b0;
      end else if (mret_flush_i) begin
         mstatus.mie  <= mstatus.mpie;
         mstatus.mpie <= 1'b1;
      end else if (csr_wr) begin
         case (wb_csr_addr_i)
            CSR_MSTATUS: begin
               mstatus.mie  <= wb_csr_wdata_i[MSTATUS_MIE];
               mstatus.mpie <= wb_csr_wdata_i[MSTATUS_MPIE];
            end
            CSR_MTVEC:    mtvec    <= wb_csr_wdata_i & ~32'h3;
            CSR_MSCRATCH: mscratch <= wb_csr_wdata_i;
            CSR_MEPC:     mepc     <= wb_csr_wdata_i & ~32'h3;
            CSR_MCAUSE:   mcause   <= wb_csr_wdata_i;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock or negedge arst_n) begin
      if (!arst_n) begin
         state            <= IDLE;
         redirect_valid_o <= 1'b0;
         redirect_pc_o    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (trap) begin
                  redirect_pc_o    <= trap_target;
                  redirect_valid_o <= 1'b1;
                  state            <= REDIRECT;
               end
            end
            REDIRECT: begin
               // A trap arriving with (or before) the accept replaces the pending target.
               if (trap) begin
                  redirect_pc_o <= trap_target;
               end else if (redirect_ready_i) begin
                  redirect_valid_o <= 1'b0;
                  state            <= IDLE;
               end
            end
            default: begin
               state            <= IDLE;
               redirect_valid_o <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      rd_data_o    = '0;
      rd_illegal_o = 1'b0;
      case (rd_addr_i)
         CSR_MSTATUS:   rd_data_o = mstatus_pack(mstatus);
         CSR_MTVEC:     rd_data_o = mtvec;
         CSR_MSCRATCH:  rd_data_o = mscratch;
         CSR_MEPC:      rd_data_o = mepc;
         CSR_MCAUSE:    rd_data_o = mcause;
         CSR_MCYCLE:    rd_data_o = mcycle[31:0];
         CSR_MCYCLEH:   rd_data_o = mcycle[63:32];
         CSR_MINSTRET:  rd_data_o = minstret[31:0];
         CSR_MINSTRETH: rd_data_o = minstret[63:32];
         CSR_MVENDORID: rd_data_o = MVENDORID;
         CSR_MARCHID:   rd_data_o = MARCHID;
         default:       rd_illegal_o = 1'b1;
      endcase
   end

endmodule
